i2c_bus_arbiter: RTL and testbench

//  Shares the single i2c_configurable engine between NUM_REQ requesters (port 0 = CPU MMIO path

---
 rtl/i2c_bus_arbiter.sv | 170 +++++++++++++++++
 tb/tb_i2c_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_bus_arbiter.sv
// Round-robin arbiter sharing one I2C engine between NUM_REQ requesters, one transaction at a time.
// Optional watchdog on the engine wait states is enabled by defining I2C_ARB_TIMEOUT_EN.
module i2c_bus_arbiter #(
  parameter int          NUM_REQ        = 2,
  parameter int          TIMEOUT_CYCLES = 4096,
  parameter logic [1:0]  ENG_MODE       = 2'b00
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NUM_REQ-1:0]     req,
  input  logic [7*NUM_REQ-1:0]   req_addr,
  input  logic [8*NUM_REQ-1:0]   req_wdata,
  input  logic [NUM_REQ-1:0]     req_rw,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [NUM_REQ-1:0]     done,
  output logic                   err,
  output logic [7:0]             rdata,
  output logic                   busy,
  output logic                   eng_en,
  output logic [6:0]             eng_addr,
  output logic [7:0]             eng_wdata,
  output logic                   eng_rw,
  output logic [1:0]             eng_mode,
  input  logic [7:0]             eng_rdata,
  input  logic                   eng_ready,
  output logic [2:0]             fsm_state
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("i2c_bus_arbiter: NUM_REQ must be 2..8 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ISSUE     = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_RESP      = 3'd4
  } state_t;

  state_t          state;
  logic [IW-1:0]   last;
  logic [IW-1:0]   owner;
  logic [IW-1:0]   pick;
  logic [IW-1:0]   idx;
  logic            pick_valid;

  assign eng_mode  = ENG_MODE;
  assign fsm_state = state;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IW-1:0] i);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // Scan from last+NUM_REQ down to last+1 so the closest requester after last wins.
  always_comb begin
    pick_valid = 1'b0;
    pick       = '0;
    idx        = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = IW'((int'(last) + k) % NUM_REQ);
      if (req[idx]) begin
        pick_valid = 1'b1;
        pick       = idx;
      end
    end
  end

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wd_cnt;
  logic          wd_hit;
  assign wd_hit = (wd_cnt == CW'(TIMEOUT_CYCLES));
`else
  assign err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      gnt       <= '0;
      done      <= '0;
      rdata     <= '0;
      busy      <= 1'b0;
      eng_en    <= 1'b0;
      eng_addr  <= '0;
      eng_wdata <= '0;
      eng_rw    <= 1'b0;
      owner     <= '0;
      last      <= IW'(NUM_REQ - 1);
`ifdef I2C_ARB_TIMEOUT_EN
      err       <= 1'b0;
      wd_cnt    <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (pick_valid && eng_ready) begin
            owner     <= pick;
            gnt       <= onehot(pick);
            eng_addr  <= req_addr[7*pick +: 7];
            eng_wdata <= req_wdata[8*pick +: 8];
            eng_rw    <= req_rw[pick];
            eng_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          eng_en <= 1'b0;
          state  <= S_WAIT_BUSY;
`ifdef I2C_ARB_TIMEOUT_EN
          wd_cnt <= '0;
`endif
        end
        S_WAIT_BUSY: begin
          if (!eng_ready) begin
            state <= S_WAIT_DONE;
`ifdef I2C_ARB_TIMEOUT_EN
            wd_cnt <= '0;
`endif
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (wd_hit) begin
            done  <= onehot(owner);
            err   <= 1'b1;
            state <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
`endif
        end
        S_WAIT_DONE: begin
          // Writes capture too: rdata always reflects the last completed transfer.
          if (eng_ready) begin
            rdata <= eng_rdata;
            done  <= onehot(owner);
            state <= S_RESP;
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (wd_hit) begin
            done  <= onehot(owner);
            err   <= 1'b1;
            state <= S_RESP;
          end else begin
            wd_cnt <= wd_cnt + CW'(1);
          end
`endif
        end
        S_RESP: begin
          done  <= '0;
          gnt   <= '0;
          busy  <= 1'b0;
          last  <= owner;
          state <= S_IDLE;
`ifdef I2C_ARB_TIMEOUT_EN
          err   <= 1'b0;
`endif
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_bus_arbiter.sv
// Bench for i2c_bus_arbiter: behavioural engine model, driver tasks, scoreboard of issue and response tuples.
// The watchdog scenario runs only when I2C_ARB_TIMEOUT_EN is defined.
module tb_i2c_bus_arbiter;
  localparam int NR = 2;
  localparam int TO = 16;
  localparam int EW = NR + 7 + 8 + 1;
  localparam int RW = NR + 1 + 8 + 7 + 8 + 1;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   req;
  logic [7*NR-1:0] req_addr;
  logic [8*NR-1:0] req_wdata;
  logic [NR-1:0]   req_rw;
  logic [NR-1:0]   gnt;
  logic [NR-1:0]   done;
  logic            err;
  logic [7:0]      rdata;
  logic            busy;
  logic            eng_en;
  logic [6:0]      eng_addr;
  logic [7:0]      eng_wdata;
  logic            eng_rw;
  logic [1:0]      eng_mode;
  logic [7:0]      eng_rdata;
  logic            eng_ready;
  logic [2:0]      fsm_state;

  i2c_bus_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYCLES(TO), .ENG_MODE(2'b00)) dut (
    .clk(clk), .rst(rst), .req(req), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_rw(req_rw), .gnt(gnt), .done(done), .err(err), .rdata(rdata), .busy(busy),
    .eng_en(eng_en), .eng_addr(eng_addr), .eng_wdata(eng_wdata), .eng_rw(eng_rw),
    .eng_mode(eng_mode), .eng_rdata(eng_rdata), .eng_ready(eng_ready), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // engine model: drops ready for busy_len cycles after a start strobe, unless stuck
  int         busy_len;
  logic [7:0] rd_val;
  bit         stuck;
  int         eng_cnt;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      eng_ready <= 1'b1;
      eng_rdata <= 8'h00;
      eng_cnt   <= 0;
    end else if (eng_en && !stuck) begin
      eng_ready <= 1'b0;
      eng_cnt   <= busy_len;
    end else if (!eng_ready && eng_cnt > 0) begin
      if (eng_cnt == 1) begin
        eng_ready <= 1'b1;
        eng_rdata <= rd_val;
      end
      eng_cnt <= eng_cnt - 1;
    end
  end

  // scoreboard
  logic [EW-1:0] eng_q[$];
  logic [RW-1:0] exp_q[$];
  int checks = 0;
  int fails  = 0;
  int cyc = 0;
  int issue_cyc = 0;
  int exp_lat = 0;
  int remaining[NR];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [NR-1:0] oh(input int i);
    logic [NR-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic expect_txn(input int i, input logic [6:0] a, input logic [7:0] w,
                            input logic rw, input logic [7:0] rd, input logic e);
    eng_q.push_back({oh(i), a, w, rw});
    exp_q.push_back({oh(i), e, rd, a, w, rw});
  endtask

  task automatic drive_req(input int i, input logic [6:0] a, input logic [7:0] w,
                           input logic rw, input int n);
    req_addr[7*i +: 7]  = a;
    req_wdata[8*i +: 8] = w;
    req_rw[i]           = rw;
    remaining[i]        = n;
    req[i]              = 1'b1;
  endtask

  // One cycle: sample on the falling edge, check issues and responses, retire requests.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (eng_en) begin
      issue_cyc = cyc;
      if (eng_q.size() == 0) check_eq("unexpected_issue", eng_q.size(), 1);
      else check_eq("issue", {gnt, eng_addr, eng_wdata, eng_rw}, eng_q.pop_front());
    end
    if (done != '0) begin
      if (exp_q.size() == 0) check_eq("unexpected_done", done, 0);
      else begin
        check_eq("resp", {done, err, rdata, eng_addr, eng_wdata, eng_rw}, exp_q.pop_front());
        check_eq("latency", cyc - issue_cyc, exp_lat);
        check_eq("gnt_in_resp", gnt, done);
      end
      for (int i = 0; i < NR; i++) begin
        if (done[i] && remaining[i] > 0) begin
          remaining[i]--;
          if (remaining[i] == 0) req[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check_eq("drained", exp_q.size(), 0);
    step();
    step();
  endtask

  initial begin
    rst = 1'b0; req = '0; req_addr = '0; req_wdata = '0; req_rw = '0;
    stuck = 1'b0; rd_val = 8'h00; busy_len = 10;
    for (int i = 0; i < NR; i++) remaining[i] = 0;

    // T1: reset with both requesting, then requester 0 wins first
    drive_req(0, 7'h21, 8'h11, 1'b1, 1);
    drive_req(1, 7'h22, 8'h22, 1'b0, 1);
    repeat (3) step();
    check_eq("reset_outs", {gnt, done, err, rdata, busy, eng_en, eng_addr, eng_wdata, eng_rw, eng_mode}, 0);
    check_eq("reset_state", fsm_state, 0);
    busy_len = 3; rd_val = 8'h5A; exp_lat = busy_len + 2;
    expect_txn(0, 7'h21, 8'h11, 1'b1, 8'h5A, 1'b0);
    expect_txn(1, 7'h22, 8'h22, 1'b0, 8'h5A, 1'b0);
    rst = 1'b1;
    wait_idle(200);

    // T2: single write, engine busy 10 cycles
    busy_len = 10; rd_val = 8'h77; exp_lat = busy_len + 2;
    expect_txn(0, 7'h50, 8'hA5, 1'b1, 8'h77, 1'b0);
    drive_req(0, 7'h50, 8'hA5, 1'b1, 1);
    wait_idle(200);
    check_eq("idle_busy", busy, 0);

    // T3: read on requester 1, rdata held afterwards
    busy_len = 4; rd_val = 8'h3C; exp_lat = busy_len + 2;
    expect_txn(1, 7'h3B, 8'h00, 1'b0, 8'h3C, 1'b0);
    drive_req(1, 7'h3B, 8'h00, 1'b0, 1);
    wait_idle(200);
    rd_val = 8'hEE;
    repeat (5) step();
    check_eq("rdata_hold", rdata, 8'h3C);

    // T4: both held for two transactions each -> 0,1,0,1
    busy_len = 2; rd_val = 8'h96; exp_lat = busy_len + 2;
    for (int k = 0; k < 2; k++) begin
      expect_txn(0, 7'h10, 8'h01, 1'b1, 8'h96, 1'b0);
      expect_txn(1, 7'h11, 8'h02, 1'b1, 8'h96, 1'b0);
    end
    drive_req(0, 7'h10, 8'h01, 1'b1, 2);
    drive_req(1, 7'h11, 8'h02, 1'b1, 2);
    wait_idle(400);

    // single requester held for three transactions is re-granted each time
    busy_len = $urandom_range(1, 6); rd_val = 8'h4D; exp_lat = busy_len + 2;
    for (int k = 0; k < 3; k++) expect_txn(1, 7'h12, 8'h33, 1'b0, 8'h4D, 1'b0);
    drive_req(1, 7'h12, 8'h33, 1'b0, 3);
    wait_idle(400);

    // owner drops req and changes its fields mid-transaction
    busy_len = 8; rd_val = 8'hE1; exp_lat = busy_len + 2;
    expect_txn(0, 7'h2A, 8'h4B, 1'b1, 8'hE1, 1'b0);
    drive_req(0, 7'h2A, 8'h4B, 1'b1, 1);
    repeat (4) step();
    req[0] = 1'b0; remaining[0] = 0;
    req_addr[6:0] = 7'h7F; req_wdata[7:0] = 8'h00; req_rw[0] = 1'b0;
    wait_idle(200);

`ifdef I2C_ARB_TIMEOUT_EN
    // T5: engine never accepts -> watchdog completes with err, rdata unchanged
    stuck = 1'b1; exp_lat = TO + 2;
    expect_txn(0, 7'h44, 8'h55, 1'b1, 8'hE1, 1'b1);
    drive_req(0, 7'h44, 8'h55, 1'b1, 1);
    wait_idle(200);
    stuck = 1'b0;
`endif

    // T6: reset in the middle of WAIT_DONE, no done pulse
    busy_len = 20; rd_val = 8'h99; exp_lat = busy_len + 2;
    expect_txn(1, 7'h31, 8'h41, 1'b0, 8'h99, 1'b0);
    drive_req(1, 7'h31, 8'h41, 1'b0, 1);
    repeat (6) step();
    rst = 1'b0;
    #1;
    check_eq("mid_reset_outs", {gnt, done, err, rdata, busy, eng_en, eng_addr, eng_wdata, eng_rw}, 0);
    check_eq("mid_reset_state", fsm_state, 0);
    exp_q.delete();
    eng_q.delete();
    req = '0;
    for (int i = 0; i < NR; i++) remaining[i] = 0;
    repeat (3) step();
    rst = 1'b1;
    repeat (2) step();
    check_eq("post_reset_busy", busy, 0);

    // recovery transaction after reset
    busy_len = 3; rd_val = 8'hC3; exp_lat = busy_len + 2;
    expect_txn(0, 7'h0F, 8'hF0, 1'b0, 8'hC3, 1'b0);
    drive_req(0, 7'h0F, 8'hF0, 1'b0, 1);
    wait_idle(200);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
